// File: rtl/count_pkg.sv
// Shared types for the count_ctrl run-control sequencer: FSM states, mode codes
// and a prescaler width helper.
package count_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        M_UP      = 2'b00,
        M_DOWN    = 2'b01,
        M_BOUNCE  = 2'b10,
        M_ONESHOT = 2'b11
    } mode_t;

    // A divide-by-1 prescaler still needs a one-bit register to stay legal.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up/down count register: synchronous clear, step enable and
// direction select, asynchronous active-low reset.
module count_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = dir_i ? (count_q - ONE) : (count_q + ONE);
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_ctrl.sv
// Run-control sequencer: start/pause/stop FSM, count-tick prescaler, mode and
// target latches, and registered wrap/done pulses around a count_core.
module count_ctrl
    import count_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int PRESC_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             stop_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] count_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             wrap_o,
    output logic             done_o
);

    localparam int              PW         = presc_width(PRESC_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state_q,  state_d;
    mode_t            mode_q,   mode_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             dir_q,    dir_d;
    logic             wrap_q,   wrap_d;
    logic             done_q,   done_d;

    logic             tick;
    logic             core_clr;
    logic             core_en;
    logic             core_dir;
    logic [WIDTH-1:0] count;

    assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        presc_d  = presc_q;
        target_d = target_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        done_d   = 1'b0;
        core_clr = 1'b0;
        core_en  = 1'b0;
        core_dir = dir_q;

        if (stop_i) begin
            state_d = S_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d  = S_RUN;
                        mode_d   = mode_t'(mode_i);
                        target_d = target_i;
                        presc_d  = '0;
                        dir_d    = (mode_t'(mode_i) == M_DOWN);
                        core_clr = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause_i) state_d = S_RUN;
                end
                S_RUN: begin
                    if (pause_i) begin
                        state_d = S_PAUSE;
                    end else if (mode_q == M_ONESHOT && count == target_q) begin
                        // Only reachable with a zero target: finish without ticking.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = tick ? '0 : (presc_q + PRESC_ONE);
                        if (tick) begin
                            core_en = 1'b1;
                            case (mode_q)
                                M_UP: begin
                                    core_dir = 1'b0;
                                    wrap_d   = (count == MAX);
                                end
                                M_DOWN: begin
                                    core_dir = 1'b1;
                                    wrap_d   = (count == '0);
                                end
                                M_BOUNCE: begin
                                    // Turn around on the endpoint so it shows only once.
                                    if (!dir_q && count == MAX) begin
                                        dir_d    = 1'b1;
                                        core_dir = 1'b1;
                                    end else if (dir_q && count == '0) begin
                                        dir_d    = 1'b0;
                                        core_dir = 1'b0;
                                    end
                                end
                                M_ONESHOT: begin
                                    core_dir = 1'b0;
                                    if ((count + ONE) == target_q) begin
                                        state_d = S_DONE;
                                        done_d  = 1'b1;
                                        presc_d = '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mode_q   <= M_UP;
            presc_q  <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
        end
    end

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (core_clr),
        .en_i    (core_en),
        .dir_i   (core_dir),
        .count_o (count)
    );

    assign count_o = count;
    assign dir_o   = dir_q;
    assign busy_o  = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign wrap_o  = wrap_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: table of command rows with hand-derived
// expected outputs, routed through a scoreboard queue, plus reset corner cases.
module tb_count_ctrl;

    localparam int WIDTH     = 3;
    localparam int PRESC_DIV = 4;

    localparam logic [1:0] MD_UP = 2'b00, MD_DN = 2'b01, MD_BN = 2'b10, MD_OS = 2'b11;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic             pause_i = 1'b0;
    logic             stop_i = 1'b0;
    logic [1:0]       mode_i = 2'b00;
    logic [WIDTH-1:0] target_i = '0;
    logic [WIDTH-1:0] count_o;
    logic             dir_o, busy_o, wrap_o, done_o;

    always #5 clk_i = ~clk_i;

    count_ctrl #(
        .WIDTH     (WIDTH),
        .PRESC_DIV (PRESC_DIV)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .pause_i  (pause_i),
        .stop_i   (stop_i),
        .mode_i   (mode_i),
        .target_i (target_i),
        .count_o  (count_o),
        .dir_o    (dir_o),
        .busy_o   (busy_o),
        .wrap_o   (wrap_o),
        .done_o   (done_o)
    );

    // Expected outputs, packed as {count, dir, busy, wrap, done}.
    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             dir;
        logic             busy;
        logic             wrap;
        logic             done;
    } exp_t;

    // One row: pulse inputs on its first cycle, run cyc edges, then compare.
    typedef struct {
        string            name;
        logic             start;
        logic             pause;
        logic             stop;
        logic [1:0]       mode;
        logic [WIDTH-1:0] target;
        int               cyc;
        exp_t             exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int wrap_seen = 0;
    int done_seen = 0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (wrap_o) wrap_seen++;
            if (done_o) done_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h ({count,dir,busy,wrap,done})",
                     name, act, req);
        end
    endtask

    function automatic vec_t mk(input string name, input logic st, input logic pa,
                                input logic sp, input logic [1:0] md,
                                input logic [WIDTH-1:0] tg, input int cyc,
                                input logic [WIDTH-1:0] cnt, input logic dr,
                                input logic bs, input logic wr, input logic dn);
        vec_t v;
        v.name   = name;
        v.start  = st;
        v.pause  = pa;
        v.stop   = sp;
        v.mode   = md;
        v.target = tg;
        v.cyc    = cyc;
        v.exp    = '{count: cnt, dir: dr, busy: bs, wrap: wr, done: dn};
        return v;
    endfunction

    task automatic add(input string name, input logic st, input logic pa, input logic sp,
                       input logic [1:0] md, input logic [WIDTH-1:0] tg, input int cyc,
                       input logic [WIDTH-1:0] cnt, input logic dr, input logic bs,
                       input logic wr, input logic dn);
        vecs.push_back(mk(name, st, pa, sp, md, tg, cyc, cnt, dr, bs, wr, dn));
    endtask

    // Called at a negedge; returns at the negedge after the row's last posedge.
    task automatic run_row(input vec_t v);
        exp_t got;
        exp_t req;
        sb_q.push_back(v.exp);
        for (int c = 0; c < v.cyc; c++) begin
            if (c > 0) @(negedge clk_i);
            start_i  = (c == 0) && v.start;
            pause_i  = (c == 0) && v.pause;
            stop_i   = (c == 0) && v.stop;
            mode_i   = v.mode;
            target_i = v.target;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        pause_i = 1'b0;
        stop_i  = 1'b0;
        got = {count_o, dir_o, busy_o, wrap_o, done_o};
        req = sb_q.pop_front();
        check(v.name, 32'(got), 32'(req));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t got;

        // Reset and idle
        add("idle20", 0, 0, 0, MD_UP, 0, 20, 0, 0, 0, 0, 0);

        // UP wrap: 1..7, 0 with wrap, then 1; stop holds the count
        add("up_1", 1, 0, 0, MD_UP, 0, PRESC_DIV + 1, 1, 0, 1, 0, 0);
        for (int i = 2; i <= 7; i++)
            add($sformatf("up_%0d", i), 0, 0, 0, MD_UP, 0, PRESC_DIV, 3'(i), 0, 1, 0, 0);
        add("up_wrap", 0, 0, 0, MD_UP, 0, PRESC_DIV, 0, 0, 1, 1, 0);
        add("up_after", 0, 0, 0, MD_UP, 0, PRESC_DIV, 1, 0, 1, 0, 0);
        add("up_stop", 0, 0, 1, MD_UP, 0, 1, 1, 0, 0, 0, 0);

        // BOUNCE: 1..7 up, 6..0 down, 1,2 up again
        add("bn_1", 1, 0, 0, MD_BN, 0, PRESC_DIV + 1, 1, 0, 1, 0, 0);
        for (int i = 2; i <= 7; i++)
            add($sformatf("bn_up_%0d", i), 0, 0, 0, MD_BN, 0, PRESC_DIV, 3'(i), 0, 1, 0, 0);
        for (int i = 6; i >= 0; i--)
            add($sformatf("bn_dn_%0d", i), 0, 0, 0, MD_BN, 0, PRESC_DIV, 3'(i), 1, 1, 0, 0);
        add("bn_turn_1", 0, 0, 0, MD_BN, 0, PRESC_DIV, 1, 0, 1, 0, 0);
        add("bn_turn_2", 0, 0, 0, MD_BN, 0, PRESC_DIV, 2, 0, 1, 0, 0);
        add("bn_stop", 0, 0, 1, MD_BN, 0, 1, 2, 0, 0, 0, 0);

        // ONESHOT to 5, then a zero-target run from DONE
        add("os_1", 1, 0, 0, MD_OS, 5, PRESC_DIV + 1, 1, 0, 1, 0, 0);
        for (int i = 2; i <= 4; i++)
            add($sformatf("os_%0d", i), 0, 0, 0, MD_OS, 5, PRESC_DIV, 3'(i), 0, 1, 0, 0);
        add("os_done", 0, 0, 0, MD_OS, 5, PRESC_DIV, 5, 0, 0, 0, 1);
        add("os_hold", 0, 0, 0, MD_OS, 5, PRESC_DIV, 5, 0, 0, 0, 0);
        add("os0_start", 1, 0, 0, MD_OS, 0, 1, 0, 0, 1, 0, 0);
        add("os0_done", 0, 0, 0, MD_OS, 0, 1, 0, 0, 0, 0, 1);
        add("os0_hold", 0, 0, 0, MD_OS, 0, 1, 0, 0, 0, 0, 0);

        // DOWN with pause/resume, pause on a tick edge, ignored start, stop on a tick
        add("dn_wrap", 1, 0, 0, MD_DN, 0, PRESC_DIV + 1, 7, 1, 1, 1, 0);
        add("dn_6", 0, 0, 0, MD_DN, 0, PRESC_DIV, 6, 1, 1, 0, 0);
        add("dn_presc1", 0, 0, 0, MD_DN, 0, 1, 6, 1, 1, 0, 0);
        add("dn_pause", 0, 1, 0, MD_DN, 0, 1, 6, 1, 1, 0, 0);
        add("dn_paused", 0, 0, 0, MD_DN, 0, 10, 6, 1, 1, 0, 0);
        add("dn_resume", 0, 1, 0, MD_DN, 0, 1, 6, 1, 1, 0, 0);
        add("dn_pre_tick", 0, 0, 0, MD_DN, 0, PRESC_DIV - 2, 6, 1, 1, 0, 0);
        add("dn_5", 0, 0, 0, MD_DN, 0, 1, 5, 1, 1, 0, 0);
        add("dn_presc3", 0, 0, 0, MD_DN, 0, PRESC_DIV - 1, 5, 1, 1, 0, 0);
        add("dn_pause_tick", 0, 1, 0, MD_DN, 0, 1, 5, 1, 1, 0, 0);
        add("dn_start_ign", 1, 0, 0, MD_UP, 0, 1, 5, 1, 1, 0, 0);
        add("dn_paused2", 0, 0, 0, MD_DN, 0, PRESC_DIV, 5, 1, 1, 0, 0);
        add("dn_resume2", 0, 1, 0, MD_DN, 0, 1, 5, 1, 1, 0, 0);
        add("dn_4", 0, 0, 0, MD_DN, 0, 1, 4, 1, 1, 0, 0);
        add("dn_3", 0, 0, 0, MD_DN, 0, PRESC_DIV, 3, 1, 1, 0, 0);
        add("dn_presc3b", 0, 0, 0, MD_DN, 0, PRESC_DIV - 1, 3, 1, 1, 0, 0);
        add("stop_on_tick", 1, 0, 1, MD_UP, 0, 1, 3, 1, 0, 0, 0);
        add("idle_after", 0, 0, 0, MD_UP, 0, 8, 3, 1, 0, 0, 0);
        add("pause_idle", 0, 1, 0, MD_UP, 0, 4, 3, 1, 0, 0, 0);

        rst_ni = 1'b0;
        #12;
        got = {count_o, dir_o, busy_o, wrap_o, done_o};
        check("reset_state", 32'(got), 32'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) run_row(vecs[i]);

        // Mid-run asynchronous reset returns to reset values without an edge
        run_row(mk("rst_run_1", 1, 0, 0, MD_UP, 0, PRESC_DIV + 1, 1, 0, 1, 0, 0));
        #2;
        rst_ni = 1'b0;
        #1;
        got = {count_o, dir_o, busy_o, wrap_o, done_o};
        check("async_reset", 32'(got), 32'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_row(mk("rst_idle", 0, 0, 0, MD_UP, 0, 6, 0, 0, 0, 0, 0));

        // One wrap each from UP and DOWN, one done each from the two ONESHOT runs
        check("wrap_pulses", 32'(wrap_seen), 32'(2));
        check("done_pulses", 32'(done_seen), 32'(2));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
